// File: rtl/cof_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cof_loader_if
// Description : Coefficient stream and active coefficient array bundle for
//               cof_loader. The master side is the host that writes
//               coefficients. The slave side is the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface cof_loader_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_TAPS = 51
);
  logic                    start;
  logic                    cof_valid;
  logic signed [WIDTH-1:0] cof_data;
  logic                    cof_ready;
  logic signed [WIDTH-1:0] data_out [0:NUM_TAPS-1];
  logic                    busy;
  logic                    done;

  modport master (
    output start, cof_valid, cof_data,
    input  cof_ready, data_out, busy, done
  );

  modport slave (
    input  start, cof_valid, cof_data,
    output cof_ready, data_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/cof_loader.sv
`default_nettype none
// ============================================================================
// Module      : cof_loader
// Description : Runtime coefficient writer for the symmetric FIR pipeline.
//               Coefficients arrive one per beat over a valid/ready stream.
//               They are staged in a shadow bank and committed atomically to
//               the active array, so the FIR never sees a partial set.
// Options     : COF_SYMMETRIC_EN - load only the first half of the taps
//               (including the centre tap) and mirror it at commit.
// Revision    : 1.0 - initial release
// ============================================================================
module cof_loader #(
  parameter int WIDTH    = 16,
  parameter int NUM_TAPS = 51
) (
  input  logic         clk,
  input  logic         rst,
  cof_loader_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_TAPS);
`ifdef COF_SYMMETRIC_EN
  localparam int N_LOAD = (NUM_TAPS + 1) / 2;
`else
  localparam int N_LOAD = NUM_TAPS;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LOAD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    beat_acc;
  logic                    ready;
  logic                    busy_q, done_q;
  logic signed [WIDTH-1:0] shadow_q [0:N_LOAD-1];
  logic signed [WIDTH-1:0] data_q   [0:NUM_TAPS-1];

  // Source shadow entry for each tap. In symmetric mode the upper half of
  // the array mirrors the lower half.
  function automatic int tap_src(input int tap);
`ifdef COF_SYMMETRIC_EN
    return (tap < N_LOAD) ? tap : (NUM_TAPS - 1 - tap);
`else
    return tap;
`endif
  endfunction

  // Next-state, index and handshake decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_acc = 1'b0;
    ready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        ready = 1'b1;
        if (bus.start) begin
          // Restart: the beat offered in this cycle is dropped
          idx_d = '0;
        end else if (bus.cof_valid) begin
          beat_acc = 1'b1;
          idx_d    = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and beat index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Registered status: busy follows the state being entered; done marks the first cycle after commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_COMMIT);
    end
  end

  // Shadow bank: capture accepted beats bit-exact at the current index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_LOAD; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_LOAD; k++) begin
        if (beat_acc && (idx_q == IDX_W'(k))) begin
          shadow_q[k] <= bus.cof_data;
        end
      end
    end
  end

  // Active array: the whole set is updated together in the COMMIT cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        data_q[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        data_q[i] <= shadow_q[tap_src(i)];
      end
    end
  end

  assign bus.cof_ready = ready;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_out  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_cof_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cof_loader
// Description : Self-checking bench for cof_loader. A cycle-level reference
//               model predicts the outputs. The bench compares every cycle
//               and adds a few hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cof_loader;
  localparam int WIDTH    = 16;
  localparam int NUM_TAPS = 5;
`ifdef COF_SYMMETRIC_EN
  localparam int N_LOAD = (NUM_TAPS + 1) / 2;
`else
  localparam int N_LOAD = NUM_TAPS;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  cof_loader_if #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS)) bus ();

  cof_loader #(.WIDTH(WIDTH), .NUM_TAPS(NUM_TAPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit               m_loading    = 0;
  bit               m_committing = 0;
  int               m_cnt        = 0;
  logic [WIDTH-1:0] m_sh   [N_LOAD]   = '{default: '0};
  logic [WIDTH-1:0] m_data [NUM_TAPS] = '{default: '0};
  bit               m_ready = 0;
  bit               m_busy  = 0;
  bit               m_done  = 0;

  function automatic int tap_src(input int tap);
`ifdef COF_SYMMETRIC_EN
    return (tap < N_LOAD) ? tap : (NUM_TAPS - 1 - tap);
`else
    return tap;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_loading = 0; m_committing = 0; m_cnt = 0;
      m_ready = 0; m_busy = 0; m_done = 0;
      for (int i = 0; i < N_LOAD; i++) m_sh[i] = '0;
      for (int i = 0; i < NUM_TAPS; i++) m_data[i] = '0;
    end else begin
      m_done = 0;
      if (m_committing) begin
        for (int i = 0; i < NUM_TAPS; i++) m_data[i] = m_sh[tap_src(i)];
        m_done = 1;
        m_committing = 0;
      end else if (m_loading) begin
        if (bus.start) begin
          m_cnt = 0;
        end else if (bus.cof_valid) begin
          m_sh[m_cnt] = bus.cof_data;
          m_cnt++;
          if (m_cnt == N_LOAD) begin
            m_loading = 0;
            m_committing = 1;
          end
        end
      end else if (bus.start) begin
        m_loading = 1;
        m_cnt = 0;
      end
      m_ready = m_loading;
      m_busy  = m_loading || m_committing;
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("cof_ready", WIDTH'(bus.cof_ready), WIDTH'(m_ready));
    check("busy",      WIDTH'(bus.busy),      WIDTH'(m_busy));
    check("done",      WIDTH'(bus.done),      WIDTH'(m_done));
    for (int i = 0; i < NUM_TAPS; i++)
      check($sformatf("data_out[%0d]", i), bus.data_out[i], m_data[i]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] d, input int max_gap);
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      bus.cof_valid = 1'b0;
      bus.cof_data  = WIDTH'($urandom);
      step();
    end
    bus.cof_valid = 1'b1;
    bus.cof_data  = d;
    for (int t = 0; t < 20 && !bus.cof_ready; t++) step();
    check("ready_wait", WIDTH'(bus.cof_ready), WIDTH'(1));
    step();
    bus.cof_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic random_load(input int max_gap);
    pulse_start();
    for (int b = 0; b < N_LOAD; b++) send_beat(WIDTH'($urandom), max_gap);
  endtask

  logic [WIDTH-1:0] dir_beats [N_LOAD];
  logic [WIDTH-1:0] dir_exp   [NUM_TAPS];
  logic [WIDTH-1:0] b_first;

  initial begin
    bus.start     = 1'b0;
    bus.cof_valid = 1'b0;
    bus.cof_data  = '0;
`ifdef COF_SYMMETRIC_EN
    dir_beats = '{16'h0010, 16'h0020, 16'h0030};
    dir_exp   = '{16'h0010, 16'h0020, 16'h0030, 16'h0020, 16'h0010};
`else
    dir_beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF};
    dir_exp   = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFF};
`endif
    #1 rst = 1'b1;
    step(); step();
    check("rst data_out[0]", bus.data_out[0], '0);
    check("rst data_out[4]", bus.data_out[NUM_TAPS-1], '0);
    check("rst cof_ready", WIDTH'(bus.cof_ready), '0);
    check("rst busy", WIDTH'(bus.busy), '0);
    check("rst done", WIDTH'(bus.done), '0);
    rst = 1'b0;
    step();

    // Directed full load, back-to-back beats
    pulse_start();
    check("ready after start", WIDTH'(bus.cof_ready), WIDTH'(1));
    for (int b = 0; b < N_LOAD; b++) begin
      send_beat(dir_beats[b], 0);
      if (b < N_LOAD - 1) check("data held during load", bus.data_out[0], '0);
    end
    check("commit busy", WIDTH'(bus.busy), WIDTH'(1));
    check("commit ready", WIDTH'(bus.cof_ready), '0);
    check("commit done", WIDTH'(bus.done), '0);
    step();
    check("done pulse", WIDTH'(bus.done), WIDTH'(1));
    check("busy after commit", WIDTH'(bus.busy), '0);
    for (int i = 0; i < NUM_TAPS; i++)
      check($sformatf("directed tap %0d", i), bus.data_out[i], dir_exp[i]);
    step();
    check("done cleared", WIDTH'(bus.done), '0);

    // Random loads with gaps in cof_valid
    for (int n = 0; n < 6; n++) begin
      random_load(3);
      repeat ($urandom_range(2, 4)) step();
    end

    // Restart mid-load: beat offered with start is dropped
    pulse_start();
    send_beat(16'h1111, 1);
    send_beat(16'h2222, 1);
    bus.start = 1'b1; bus.cof_valid = 1'b1; bus.cof_data = 16'hDEAD;
    step();
    bus.start = 1'b0; bus.cof_valid = 1'b0;
    b_first = 16'h0B0B;
    send_beat(b_first, 2);
    for (int b = 1; b < N_LOAD; b++) send_beat(WIDTH'($urandom), 2);
    step();
    check("restart first tap is B", bus.data_out[0], b_first);
    step();

    // Start during COMMIT is ignored; start in the done cycle is accepted
    random_load(1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("done after commit-start", WIDTH'(bus.done), WIDTH'(1));
    check("idle after commit-start", WIDTH'(bus.busy), '0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start in done cycle ready", WIDTH'(bus.cof_ready), WIDTH'(1));
    check("start in done cycle busy", WIDTH'(bus.busy), WIDTH'(1));
    for (int b = 0; b < N_LOAD; b++) send_beat(WIDTH'($urandom), 1);
    step(); step();

    // Reset mid-load clears the active set
    pulse_start();
    for (int b = 0; b < ((N_LOAD > 3) ? 3 : N_LOAD - 1); b++) send_beat(WIDTH'($urandom), 0);
    rst = 1'b1;
    #1;
    check("mid-load rst data_out[0]", bus.data_out[0], '0);
    check("mid-load rst busy", WIDTH'(bus.busy), '0);
    check("mid-load rst ready", WIDTH'(bus.cof_ready), '0);
    step();
    rst = 1'b0;
    step();

    // Free-running random traffic including stray valids and restarts
    for (int c = 0; c < 400; c++) begin
      bus.start     = ($urandom_range(0, 15) == 0);
      bus.cof_valid = $urandom_range(0, 1) == 1;
      bus.cof_data  = WIDTH'($urandom);
      rst           = ($urandom_range(0, 199) == 0);
      step();
    end
    bus.start = 1'b0; bus.cof_valid = 1'b0; rst = 1'b0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cof_loader.md
# cof_loader

Runtime coefficient writer for the symmetric FIR pipeline. Accepts filter coefficients one per beat over a valid/ready stream, stages them in a shadow bank, and atomically commits the full set to a parallel coefficient array on the last beat. Its `data_out` is a drop-in source for the FIR tap multipliers, so coefficients can be reprogrammed from a host/UART path without resynthesis. The FIR never sees a partially written set.

## Interface
- `WIDTH`, default 16: signed coefficient width.
- `NUM_TAPS`, default 51: number of FIR taps (≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new load sequence.
- `cof_valid` in 1: `cof_data` is valid this cycle.
- `cof_data` in WIDTH: signed coefficient beat.
- `cof_ready` out 1: loader accepts a beat this cycle.
- `data_out` out WIDTH × NUM_TAPS, unpacked `[0:NUM_TAPS-1]`, signed: active coefficient array.
- `busy` out 1: loader is in LOAD or COMMIT.
- `done` out 1: one-cycle pulse, high in the first cycle new `data_out` is visible.

## Operation
- `N_LOAD` = number of beats per load; see Configuration. Index counter is `$clog2(NUM_TAPS)` bits.
- **Reset values:**
  - `data_out` all zero; shadow bank all zero.
  - `cof_ready`=0, `busy`=0, `done`=0.
  - Index = 0; state IDLE.
- **IDLE**
  - `cof_ready`=0.
  - `start`=1 → LOAD; index ← 0.
- **LOAD**
  - `cof_ready`=1.
  - Beat accepted when `cof_valid & cof_ready` → shadow[index] ← `cof_data`; index ← index+1.
  - Accepted beat with index = N_LOAD−1 → COMMIT.
- **COMMIT** (exactly one cycle)
  - `cof_ready`=0.
  - At the closing edge: `data_out` ← shadow (mapped per Configuration); `done` ← 1; → IDLE.
- `done` is registered and clears after one cycle.
- `busy` is a registered decode of state ≠ IDLE.
- `data_out` changes only at the COMMIT edge and at reset. It holds its value through all of LOAD.
- **Boundary conditions:**
  - `start` during LOAD: restart. Index ← 0; the beat in that cycle is discarded even if `cof_valid`=1. `data_out` is untouched.
  - `start` during COMMIT: ignored; the commit completes normally.
  - `start` in the IDLE cycle where `done`=1: accepted, → LOAD.
  - `cof_valid` in IDLE or COMMIT: ignored; no write.
  - `rst` mid-LOAD or mid-COMMIT: immediate return to reset values, including `data_out` = 0. The previous active set is not retained.
  - No arithmetic on data: `cof_data` is stored bit-exact.

## Timing
- `start` sampled at edge t0 → `cof_ready`=1 from cycle t0+1.
- Back-to-back beats: one per cycle while `cof_valid`=1.
- Last beat accepted at edge tL:
  - COMMIT during cycle tL+1.
  - New `data_out` and `done`=1 during cycle tL+2.
  - `busy`=0 during cycle tL+2.
- Minimum load: N_LOAD + 2 cycles from the `start` edge to `done`.
- Gaps in `cof_valid` stretch LOAD indefinitely. There is no timeout.

## Configuration
- `COF_SYMMETRIC_EN` defined:
  - N_LOAD = (NUM_TAPS+1)/2.
  - At commit, `data_out[i]` and `data_out[NUM_TAPS-1-i]` ← shadow[i] for i < N_LOAD. For odd NUM_TAPS the centre tap is written once.
  - The shadow bank is N_LOAD entries.
- `COF_SYMMETRIC_EN` undefined:
  - N_LOAD = NUM_TAPS.
  - `data_out[i]` ← shadow[i] for every tap.

## Test plan
- Tests use NUM_TAPS=5 and WIDTH=16 unless stated.
- **Reset:** assert `rst` → all `data_out`=0, `cof_ready`=0, `busy`=0, `done`=0. Deassert → IDLE.
- **Full load, macro undefined:**
  - `start`, then beats 0x0001, 0x0002, 0x0003, 0x0004, 0xFFFF back-to-back.
  - `data_out` = {1,2,3,4,−1} exactly 2 cycles after the last beat edge; `done` high for one cycle.
  - `data_out` stays 0 throughout LOAD.
- **Symmetric load, macro defined:**
  - Beats 0x0010, 0x0020, 0x0030, then `cof_ready` drops.
  - `data_out` = {0x10,0x20,0x30,0x20,0x10}.
  - Repeat with NUM_TAPS=4: beats 0x0A, 0x0B → {0x0A,0x0B,0x0B,0x0A}.
- **Backpressure/gaps:** toggle `cof_valid` randomly → only valid&ready beats stored, in order. Commit timing is unchanged relative to the last beat.
- **Restart:**
  - After 2 beats of load A, pulse `start` with `cof_valid`=1; that beat is dropped.
  - Load B completes → `data_out` holds only B values.
  - Prior committed set is visible until B's commit.
- **Reset mid-LOAD and start in COMMIT:**
  - `rst` after 3 beats → `data_out`=0, IDLE.
  - Separately, `start` asserted during the COMMIT cycle → ignored; `done` pulses; `busy`=0 afterward.
